// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block.
package stopwatch_pkg;

  localparam int BCD_W = 16;

  localparam logic [BCD_W-1:0] DEF_LOAD_PRESET = 16'h0500;
  localparam logic [BCD_W-1:0] MAX_COUNT       = 16'h5959;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_UP      = 3'd1,
    ST_DOWN    = 3'd2,
    ST_ERROR   = 3'd3,
    ST_EXPIRED = 3'd4
  } state_t;

endpackage

// File: rtl/stopwatch_btn_sync.sv
// Button synchroniser with a level output and single-cycle rise/fall detects.
module btn_sync
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button synchronisation, tick prescaler and
// clear/load/error/expiry sequencing for the mm:ss BCD counter.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int                TICK_DIV    = 50,
  parameter int                SYNC_STAGES = 2,
  parameter logic [BCD_W-1:0]  LOAD_PRESET = DEF_LOAD_PRESET
) (
  input  logic             MCLK,
  input  logic             MR,
  input  logic             MS,
  input  logic             MM,
  input  logic             ML,
  input  logic             MC,
  input  logic             CNT_ZERO,
  input  logic             CNT_MAX,
  output logic             TICK_EN,
  output logic             CNT_UP,
  output logic             CNT_CLR,
  output logic             CNT_LD,
  output logic [BCD_W-1:0] LD_VAL,
  output logic             ERR,
  output logic             DONE,
  output logic [2:0]       STATE
);

  localparam int            PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Button index: 0 = run, 1 = mode, 2 = load, 3 = clear.
  logic [3:0] btn_raw;
  logic [3:0] btn_lvl;
  logic [3:0] btn_rise;
  logic [3:0] btn_fall;

  assign btn_raw = {MC, ML, MM, MS};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (MCLK),
        .rst_n (MR),
        .btn   (btn_raw[gi]),
        .level (btn_lvl[gi]),
        .rise  (btn_rise[gi]),
        .fall  (btn_fall[gi])
      );
    end
  endgenerate

  logic ms_lvl, mm_lvl, ms_rise, ml_fall, mc_rise;
  assign ms_lvl  = btn_lvl[0];
  assign mm_lvl  = btn_lvl[1];
  assign ms_rise = btn_rise[0];
  assign ml_fall = btn_fall[2];
  assign mc_rise = btn_rise[3];

  logic unused_edges;
  assign unused_edges = ^{btn_lvl[3:2], btn_rise[2:1], btn_fall[3], btn_fall[1:0]};

  state_t        state_reg;
  logic [PW-1:0] presc_reg;

  always_ff @(posedge MCLK or negedge MR) begin
    if (!MR) begin
      state_reg <= ST_IDLE;
      presc_reg <= '0;
      TICK_EN   <= 1'b0;
      CNT_CLR   <= 1'b0;
      CNT_LD    <= 1'b0;
      CNT_UP    <= 1'b0;
      ERR       <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      TICK_EN <= 1'b0;
      CNT_CLR <= 1'b0;
      CNT_LD  <= 1'b0;
      if (mc_rise) begin
        CNT_CLR   <= 1'b1;
        state_reg <= ST_IDLE;
        presc_reg <= '0;
        ERR       <= 1'b0;
        DONE      <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            presc_reg <= '0;
            // A release coinciding with the run press loads first; the run
            // is picked up next cycle because the run level stays high.
            if (ml_fall && (!ms_lvl || ms_rise)) begin
              CNT_LD <= 1'b1;
            end else if (ms_lvl && !mm_lvl) begin
              state_reg <= ST_UP;
              CNT_UP    <= 1'b1;
            end else if (ms_lvl && mm_lvl && !CNT_ZERO) begin
              state_reg <= ST_DOWN;
              CNT_UP    <= 1'b0;
            end
          end
          ST_UP: begin
            if (!ms_lvl) begin
              state_reg <= ST_IDLE;
              presc_reg <= '0;
            end else if (mm_lvl) begin
              state_reg <= ST_ERROR;
              ERR       <= 1'b1;
              presc_reg <= '0;
            end else if (presc_reg == PRESC_LAST) begin
              presc_reg <= '0;
              TICK_EN   <= !CNT_MAX;
            end else begin
              presc_reg <= presc_reg + 1'b1;
            end
          end
          ST_DOWN: begin
            if (!ms_lvl) begin
              state_reg <= ST_IDLE;
              presc_reg <= '0;
            end else if (!mm_lvl) begin
              state_reg <= ST_ERROR;
              ERR       <= 1'b1;
              presc_reg <= '0;
            end else if (CNT_ZERO) begin
              state_reg <= ST_EXPIRED;
              DONE      <= 1'b1;
              presc_reg <= '0;
            end else if (presc_reg == PRESC_LAST) begin
              presc_reg <= '0;
              TICK_EN   <= 1'b1;
            end else begin
              presc_reg <= presc_reg + 1'b1;
            end
          end
          ST_ERROR: begin
            presc_reg <= '0;
          end
          ST_EXPIRED: begin
            presc_reg <= '0;
            if (!ms_lvl) begin
              state_reg <= ST_IDLE;
              DONE      <= 1'b0;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            presc_reg <= '0;
          end
        endcase
      end
    end
  end

  assign STATE  = state_reg;
  assign LD_VAL = LOAD_PRESET;

endmodule
